// File: rtl/panel_reg_writer_pkg.sv
// Shared definitions for the front-panel register-entry controller.
package panel_reg_writer_pkg;

    localparam int IDX_W      = 3;
    localparam int KEY_ENTER  = 0;
    localparam int KEY_CANCEL = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int num_regs);
        return 32'(idx) < 32'(num_regs);
    endfunction

endpackage

// File: rtl/panel_reg_writer_key_debouncer.sv
// Synchronises and debounces one active-low push-button; emits a one-cycle
// pulse on each accepted press (debounced 1->0).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync        <= 2'b11;
            key_level   <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync        <= {sync[0], key_raw};
            press_pulse <= 1'b0;
            if (sync[1] == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Level has disagreed long enough: accept it.
                cnt         <= '0;
                key_level   <= sync[1];
                press_pulse <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_reg_writer.sv
// Front-panel register entry: index step, data step, then a single
// valid/ready write into the processor register file with a timeout.
module panel_reg_writer
    import panel_reg_writer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_REGS        = 5,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       SW,
    input  logic [1:0]        KEY,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [IDX_W-1:0]  wr_addr,
    output logic [15:0]       wr_data,
    output logic [1:0]        stage,
    output logic              err,
    output logic              done,
    output logic [7:0]        write_count
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0] key_level;
    logic [1:0] press;
    logic       unused_levels;

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .Clock      (Clock),
            .Reset      (Reset),
            .key_raw    (KEY[k]),
            .key_level  (key_level[k]),
            .press_pulse(press[k])
        );
    end

    assign unused_levels = ^key_level;

    logic enter_p, cancel_p;
    assign enter_p  = press[KEY_ENTER];
    assign cancel_p = press[KEY_CANCEL];

    state_t           state, state_n;
    logic             wr_valid_n;
    logic [IDX_W-1:0] wr_addr_n;
    logic [15:0]      wr_data_n;
    logic             err_n;
    logic             done_n;
    logic [7:0]       write_count_n;
    logic [TO_W-1:0]  tcnt, tcnt_n;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            write_count <= '0;
            tcnt        <= '0;
        end else begin
            state       <= state_n;
            wr_valid    <= wr_valid_n;
            wr_addr     <= wr_addr_n;
            wr_data     <= wr_data_n;
            err         <= err_n;
            done        <= done_n;
            write_count <= write_count_n;
            tcnt        <= tcnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        wr_valid_n    = wr_valid;
        wr_addr_n     = wr_addr;
        wr_data_n     = wr_data;
        err_n         = err;
        done_n        = 1'b0;
        write_count_n = write_count;
        tcnt_n        = tcnt;

        case (state)
            ST_IDLE: begin
                if (enter_p) begin
                    if (idx_in_range(SW[IDX_W-1:0], NUM_REGS)) begin
                        wr_addr_n = SW[IDX_W-1:0];
                        err_n     = 1'b0;
                        state_n   = ST_ADDR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                // Cancel outranks a simultaneous enter.
                if (cancel_p) begin
                    state_n = ST_IDLE;
                end else if (enter_p) begin
                    wr_data_n  = SW;
                    wr_valid_n = 1'b1;
                    tcnt_n     = '0;
                    state_n    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Keys are deliberately ignored here; a transfer beats the timeout.
                if (wr_ready) begin
                    wr_valid_n    = 1'b0;
                    done_n        = 1'b1;
                    write_count_n = write_count + 8'd1;
                    state_n       = ST_IDLE;
                end else if (tcnt == TO_MAX) begin
                    wr_valid_n = 1'b0;
                    err_n      = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: begin
                wr_valid_n = 1'b0;
                state_n    = ST_IDLE;
            end
        endcase
    end

    assign stage = state;

endmodule

// File: tb/tb_panel_reg_writer.sv
// Scoreboarded bench for panel_reg_writer: stimulus queues expected writes,
// a negedge monitor checks each transfer, done pulse and count.
module tb_panel_reg_writer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] SW;
    logic [1:0]  KEY;
    logic        wr_ready;
    logic        wr_valid;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  stage;
    logic        err;
    logic        done;
    logic [7:0]  write_count;

    panel_reg_writer #(
        .DEBOUNCE_CYCLES(4),
        .NUM_REGS       (5),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .SW         (SW),
        .KEY        (KEY),
        .wr_ready   (wr_ready),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .stage      (stage),
        .err        (err),
        .done       (done),
        .write_count(write_count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer.
    logic [7:0] mon_count;
    logic       pend_done;
    logic       prev_stall;
    wr_t        prev_req;
    wr_t        mon_e;

    always @(negedge Clock) begin
        if (Reset) begin
            mon_count  = 8'd0;
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (done || pend_done) chk("done_pulse", 32'(done), 32'(pend_done));
            if (pend_done) chk("mon_write_count", 32'(write_count), 32'(mon_count));
            pend_done = 1'b0;
            if (prev_stall && wr_valid) chk("req_stable", 32'({wr_addr, wr_data}), 32'(prev_req));
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h, expected none", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                end
                mon_count = mon_count + 8'd1;
                pend_done = 1'b1;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_req   = {wr_addr, wr_data};
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Hold the masked keys low long enough for a press, then release and settle.
    task automatic press(input logic [1:0] mask);
        KEY = ~mask;
        repeat (7) cyc();
        KEY = 2'b11;
        repeat (9) cyc();
    endtask

    // Hold enter until wr_valid appears; the caller releases the key.
    task automatic enter_write();
        int n = 0;
        KEY[0] = 1'b0;
        do begin
            cyc();
            n++;
        end while (!wr_valid && n < 20);
        if (!wr_valid) begin
            checks++;
            errors++;
            $display("FAIL enter_write_timeout: wr_valid %0b, required 1", wr_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset = 1'b1; KEY = 2'b11; SW = '0; wr_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_wr_valid", 32'(wr_valid), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(write_count), 0);
        Reset = 1'b0;
        cyc();

        // Glitch rejection: 2 and 3 cycle lows.
        SW = 16'd1;
        KEY[0] = 1'b0; repeat (2) cyc(); KEY[0] = 1'b1; repeat (10) cyc();
        chk("glitch2_stage", 32'(stage), 0);
        KEY[0] = 1'b0; repeat (3) cyc(); KEY[0] = 1'b1; repeat (10) cyc();
        chk("glitch3_stage", 32'(stage), 0);

        // Normal write with ready already high.
        SW = 16'd3;
        press(2'b01);
        chk("addr_stage", 32'(stage), 1);
        chk("addr_latched", 32'(wr_addr), 3);
        SW = 16'hBEEF;
        exp_q.push_back('{addr: 3'd3, data: 16'hBEEF});
        wr_ready = 1'b1;
        enter_write();
        cyc();
        chk("one_cycle_valid", 32'(wr_valid), 0);
        chk("normal_done", 32'(done), 1);
        chk("normal_count", 32'(write_count), 1);
        chk("normal_stage", 32'(stage), 0);
        KEY[0] = 1'b1; wr_ready = 1'b0;
        repeat (10) cyc();

        // Bad index then good index.
        SW = 16'd7;
        press(2'b01);
        chk("bad_idx_err", 32'(err), 1);
        chk("bad_idx_stage", 32'(stage), 0);
        SW = 16'd2;
        press(2'b01);
        chk("good_idx_err", 32'(err), 0);
        chk("good_idx_stage", 32'(stage), 1);

        // Enter+cancel together in ADDR: cancel wins, address retained.
        press(2'b11);
        chk("prec_stage", 32'(stage), 0);
        chk("prec_valid", 32'(wr_valid), 0);
        chk("prec_addr_kept", 32'(wr_addr), 2);

        // Timeout with no ready.
        SW = 16'd4;
        press(2'b01);
        SW = 16'h1234;
        enter_write();
        KEY[0] = 1'b1;
        n = 0;
        while (wr_valid && n < 20) begin
            n++;
            cyc();
        end
        chk("timeout_valid_cycles", 32'(n), 8);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_stage", 32'(stage), 0);
        chk("timeout_count", 32'(write_count), 1);
        repeat (10) cyc();

        // Cancel ignored in WRITE; ready on the last cycle still transfers.
        SW = 16'd1;
        press(2'b01);
        chk("idx1_err", 32'(err), 0);
        SW = 16'hCAFE;
        exp_q.push_back('{addr: 3'd1, data: 16'hCAFE});
        enter_write();
        KEY = 2'b01;
        repeat (7) cyc();
        chk("cancel_ignored_valid", 32'(wr_valid), 1);
        chk("cancel_ignored_stage", 32'(stage), 2);
        chk("cancel_ignored_data", 32'(wr_data), 16'hCAFE);
        wr_ready = 1'b1;
        cyc();
        wr_ready = 1'b0;
        chk("late_ready_valid", 32'(wr_valid), 0);
        chk("late_ready_done", 32'(done), 1);
        chk("late_ready_count", 32'(write_count), 2);
        KEY = 2'b11;
        repeat (10) cyc();

        // Wrap write_count back to 0.
        for (int i = 0; i < 254; i++) begin
            SW = 16'(i % 5);
            press(2'b01);
            SW = 16'(i * 7 + 1);
            exp_q.push_back('{addr: 3'(i % 5), data: 16'(i * 7 + 1)});
            wr_ready = 1'b1;
            press(2'b01);
            wr_ready = 1'b0;
        end
        chk("wrap_count", 32'(write_count), 0);

        // Reset while a write is outstanding.
        SW = 16'd0;
        press(2'b01);
        SW = 16'h5555;
        enter_write();
        chk("pre_reset_valid", 32'(wr_valid), 1);
        Reset = 1'b1;
        cyc();
        chk("mid_rst_valid", 32'(wr_valid), 0);
        chk("mid_rst_addr", 32'(wr_addr), 0);
        chk("mid_rst_data", 32'(wr_data), 0);
        chk("mid_rst_stage", 32'(stage), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_count", 32'(write_count), 0);
        KEY = 2'b11;
        Reset = 1'b0;
        repeat (10) cyc();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/panel_reg_writer.md
Name: panel_reg_writer

Overview:
Front-panel register-entry controller: the input/write side of the board panel, the counterpart of the HEX register display path. It debounces two push-buttons and takes a register index and then a 16-bit value from the switches in two operator steps. It then delivers one write to the processor register file over a valid/ready handshake. It sits between the board KEY/SW pins and the processor's debug write port, in the Clock domain.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key level change is accepted (use 4 in simulation)
NUM_REGS, 5, number of writable registers; valid indices are 0..NUM_REGS-1
TIMEOUT_CYCLES, 1024, maximum cycles wr_valid is held without wr_ready before the write is abandoned

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
SW  input  16  switch value; SW[2:0] is the register index in the address step, SW[15:0] is the data in the data step
KEY  input  2  raw, active-low, asynchronous buttons; KEY[0]=enter, KEY[1]=cancel
wr_ready  input  1  processor accepts the write this cycle
wr_valid  output  1  write request
wr_addr  output  3  register index
wr_data  output  16  register value
stage  output  2  0=await index, 1=await data, 2=writing (for LEDG)
err  output  1  sticky error flag
done  output  1  one-cycle pulse on a completed write
write_count  output  8  completed writes, wraps 255->0

Behaviour:
- Reset (synchronous, active-high): wr_valid=0, wr_addr=0, wr_data=0, stage=0, err=0, done=0, write_count=0, state=IDLE, debounced key levels=1 (released), debounce and timeout counters=0. Reset mid-write drops wr_valid on the next edge with no completion.
- Key path, per key:
  - 2-flop synchroniser.
  - Debounce counter: counts while the synchronised level differs from the debounced level, and clears when they match.
  - On reaching DEBOUNCE_CYCLES-1, the debounced level flips.
  - A debounced 1->0 transition produces a one-cycle press pulse.
  - Latency from a stable raw edge to the press pulse is DEBOUNCE_CYCLES+2 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: IDLE(stage 0), ADDR(stage 1), WRITE(stage 2). All outputs are registered.
- IDLE:
  - On an enter press with SW[2:0]<NUM_REGS: wr_addr<=SW[2:0], err<=0, go to ADDR.
  - On an enter press with SW[2:0]>=NUM_REGS: err<=1, stay in IDLE.
  - Cancel: no effect.
- ADDR:
  - Enter press: wr_data<=SW[15:0], wr_valid<=1, go to WRITE. wr_valid is high on the cycle after the press pulse.
  - Cancel press: go to IDLE; wr_addr is retained.
  - Enter and cancel on the same cycle: cancel wins.
- WRITE:
  - wr_valid, wr_addr and wr_data stay stable until they are consumed.
  - Transfer occurs on the edge where wr_valid&&wr_ready. Next cycle: wr_valid=0, done=1 for one cycle, write_count+1, state IDLE.
  - wr_ready while not in WRITE is ignored.
  - All key presses in WRITE are ignored, including cancel; the handshake is never withdrawn by the operator.
  - Timeout counter starts at 0 on entry and increments each cycle without ready. If ready has not arrived when it reaches TIMEOUT_CYCLES-1: wr_valid<=0, err<=1, go to IDLE, write_count unchanged.
  - Ready arriving on the same cycle as the timeout: the transfer wins.
- err is cleared only by reset or by a valid index entry.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ADDR=2'd1, WRITE=2'd2), KEY_ENTER=0, KEY_CANCEL=1, and the register-index width (3).
- One natural sub-module: key_debouncer, parameter DEBOUNCE_CYCLES. Ports: Clock, Reset, key_raw, key_level, press_pulse. Instantiate it twice.

Test Plan:
- Use DEBOUNCE_CYCLES=4 for all scenarios.
- Glitch rejection: pulse KEY[0] low for 2 cycles, then 3 cycles -> no press, stage stays 0.
- Normal write: SW=3, hold KEY[0] low for 10 cycles, release; SW=16'hBEEF, press again; wr_ready=1 -> wr_valid for exactly 1 cycle with wr_addr=3 and wr_data=BEEF, done pulse, write_count=1, stage=0.
- Bad index: SW[2:0]=7, press enter -> err=1, stage=0. Then SW=2, press -> err=0, stage=1.
- Cancel and precedence:
  - In ADDR, press KEY[0] and KEY[1] together -> stage=0, wr_valid never asserts.
  - In WRITE, press cancel -> ignored, wr_valid stays 1.
- Backpressure and timeout:
  - TIMEOUT_CYCLES=8 with wr_ready=0 -> wr_valid holds with data stable for 8 cycles, then drops; err=1, write_count unchanged.
  - Ready on cycle 8 -> the transfer is counted.
- Wrap and reset: 256 writes -> write_count=0. Assert Reset while in WRITE -> wr_valid=0 next edge and all outputs at their reset values.
